// File: rtl/sp_ram_arb_pkg.sv
// Shared widths, request payload type, priority encoding and counter helper for sp_ram_arb.
package sp_ram_arb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned CNT_W      = 16;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } ram_req_t;

    typedef enum logic {
        PRIO_0 = 1'b0,
        PRIO_1 = 1'b1
    } prio_e;

    // Saturating increment; holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sp_ram_arb_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    prio_e prio_q, prio_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant and pointer update; pointer moves to the loser after any grant.
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (!rst) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (prio_q == PRIO_0) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[0]) begin
            prio_d = PRIO_1;
        end else if (gnt_o[1]) begin
            prio_d = PRIO_0;
        end
    end

endmodule

// File: rtl/sp_ram_arb.sv
// Two-requester front end for a single-port synchronous RAM (e.g. sp_ram8x16).
// Optional per-requester grant counters enabled by SP_RAM_ARB_STATS_EN.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_we,
`ifdef SP_RAM_ARB_STATS_EN
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1,
`endif
    input  logic [DATA_W-1:0] ram_d_out
);

    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [1:0]        rvalid_q, rvalid_d;

    rr_arb2 u_arb (
        .clk   (wclk),
        .rst   (rst),
        .req_i ({req1, req0}),
        .gnt_o (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // RAM port mux: granted requester drives the RAM, otherwise address/data hold.
    always_comb begin
        addr_d   = addr_q;
        din_d    = din_q;
        ram_we   = 1'b0;
        rvalid_d = 2'b00;
        if (rst) begin
            addr_d = '0;
            din_d  = '0;
        end else if (gnt[0]) begin
            addr_d      = addr0;
            din_d       = wdata0;
            ram_we      = we0;
            rvalid_d[0] = ~we0;
        end else if (gnt[1]) begin
            addr_d      = addr1;
            din_d       = wdata1;
            ram_we      = we1;
            rvalid_d[1] = ~we1;
        end
    end

    assign ram_addr = addr_d;
    assign ram_d_in = din_d;

    always_ff @(posedge wclk) begin
        if (rst) begin
            addr_q   <= '0;
            din_q    <= '0;
            rvalid_q <= 2'b00;
        end else begin
            addr_q   <= addr_d;
            din_q    <= din_d;
            rvalid_q <= rvalid_d;
        end
    end

    // RAM read data lines up with rvalid one cycle after the read grant.
    assign rvalid0 = rvalid_q[0] & ~rst;
    assign rvalid1 = rvalid_q[1] & ~rst;
    assign rdata   = ram_d_out;

`ifdef SP_RAM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge wclk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt[0]) cnt0_q <= sat_inc(cnt0_q);
            if (gnt[1]) cnt1_q <= sat_inc(cnt1_q);
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_sp_ram_arb.sv
// Scoreboard bench for sp_ram_arb with a behavioural 8x16 synchronous RAM.
module tb_sp_ram_arb;
    import sp_ram_arb_pkg::*;

    logic        wclk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [2:0]  ram_addr;
    logic [15:0] ram_d_in;
    logic        ram_we;
    logic [15:0] ram_d_out;
`ifdef SP_RAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    sp_ram_arb #(.DATA_W(16), .ADDR_W(3)) dut (
        .wclk      (wclk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_d_in  (ram_d_in),
        .ram_we    (ram_we),
`ifdef SP_RAM_ARB_STATS_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .ram_d_out (ram_d_out)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Behavioural single-port RAM, one-cycle read latency.
    logic [15:0] mem [8];
    always @(posedge wclk) begin
        if (ram_we) mem[ram_addr] <= ram_d_in;
        ram_d_out <= mem[ram_addr];
    end

    int unsigned cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rst;
        logic       req0;
        logic       req1;
        ram_req_t   p0;
        ram_req_t   p1;
        logic [1:0] gnt;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  gnt;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] din;
        logic        chk_cnt;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
    } cyc_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        port;
        logic [15:0] data;
    } rd_exp_t;

    cyc_exp_t    cyc_q[$];
    rd_exp_t     rd_q[$];
    logic [15:0] exp_mem [8];
    logic [2:0]  last_addr = 3'd0;
    logic [15:0] last_din  = 16'd0;
    logic        chk_cnt_nx = 1'b0;
    logic [15:0] e_cnt0 = 16'd0, e_cnt1 = 16'd0;
    logic        mon_en = 1'b0, stim_done = 1'b0, mon_done = 1'b0;
    int          n_tests = 0, n_fail = 0;

    function automatic vec_t mk(input logic r, input logic r0, input logic r1,
                                input logic w0, input logic [2:0] a0, input logic [15:0] d0,
                                input logic w1, input logic [2:0] a1, input logic [15:0] d1,
                                input logic [1:0] g);
        vec_t v;
        v.rst  = r;
        v.req0 = r0;
        v.req1 = r1;
        v.p0   = '{we: w0, addr: a0, wdata: d0};
        v.p1   = '{we: w1, addr: a1, wdata: d1};
        v.gnt  = g;
        return v;
    endfunction

    // Drive one cycle and push what the DUT must show this cycle and, for reads, next cycle.
    task automatic apply(input vec_t v);
        cyc_exp_t ce;
        rst = v.rst; req0 = v.req0; req1 = v.req1;
        we0 = v.p0.we; addr0 = v.p0.addr; wdata0 = v.p0.wdata;
        we1 = v.p1.we; addr1 = v.p1.addr; wdata1 = v.p1.wdata;
        ce.cyc = cyc; ce.gnt = v.gnt; ce.we = 1'b0;
        ce.chk_cnt = chk_cnt_nx; ce.cnt0 = e_cnt0; ce.cnt1 = e_cnt1;
        if (v.rst) begin
            last_addr = 3'd0;
            last_din  = 16'd0;
        end else if (v.gnt[0] || v.gnt[1]) begin
            ram_req_t p;
            p = v.gnt[0] ? v.p0 : v.p1;
            ce.we     = p.we;
            last_addr = p.addr;
            last_din  = p.wdata;
            if (p.we) exp_mem[p.addr] = p.wdata;
            else rd_q.push_back('{cyc: cyc + 1, port: v.gnt[1], data: exp_mem[p.addr]});
        end
        ce.addr = last_addr;
        ce.din  = last_din;
        cyc_q.push_back(ce);
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge.
    always @(negedge wclk) begin : monitor
        cyc_exp_t ce;
        rd_exp_t  re;
        if (mon_en && !mon_done) begin
            if (cyc_q.size() != 0 && cyc_q[0].cyc == cyc) begin
                ce = cyc_q.pop_front();
                chk("gnt", 32'({gnt1, gnt0}), 32'(ce.gnt));
                chk("ram_we", 32'(ram_we), 32'(ce.we));
                chk("ram_addr", 32'(ram_addr), 32'(ce.addr));
                chk("ram_d_in", 32'(ram_d_in), 32'(ce.din));
`ifdef SP_RAM_ARB_STATS_EN
                if (ce.chk_cnt) begin
                    chk("gnt_cnt0", 32'(gnt_cnt0), 32'(ce.cnt0));
                    chk("gnt_cnt1", 32'(gnt_cnt1), 32'(ce.cnt1));
                end
`endif
            end
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
                re = rd_q.pop_front();
                chk("rvalid", 32'({rvalid1, rvalid0}), re.port ? 32'd2 : 32'd1);
                chk("rdata", 32'(rdata), 32'(re.data));
            end else begin
                chk("rvalid_idle", 32'({rvalid1, rvalid0}), 32'd0);
            end
            if (stim_done) begin
                chk("sb_drain", 32'(cyc_q.size() + rd_q.size()), 32'd0);
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0; wdata0 = 16'd0; wdata1 = 16'd0;
        @(posedge wclk);
        #1;
        mon_en = 1'b1;

        // Reset held with both requesting: nothing may be granted.
        repeat (3) apply(mk(1, 1, 1, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));

        // Single writer fills the RAM.
        for (int a = 0; a < 8; a++)
            apply(mk(0, 1, 0, 1, 3'(a), 16'h1000 + 16'(a), 0, 3'd0, 16'd0, 2'b01));

        // Solo read moves prio to 1; idle holds address/data; reset returns prio to 0.
        apply(mk(0, 1, 0, 0, 3'd3, 16'h5555, 0, 3'd0, 16'd0, 2'b01));
        apply(mk(0, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));
        apply(mk(1, 1, 1, 0, 3'd3, 16'd0, 0, 3'd5, 16'd0, 2'b00));

        // Contention right after reset: requester 0 first, then alternate.
        apply(mk(0, 1, 1, 0, 3'd3, 16'd0, 0, 3'd5, 16'd0, 2'b01));
        apply(mk(0, 1, 1, 0, 3'd3, 16'd0, 0, 3'd5, 16'd0, 2'b10));
        apply(mk(0, 1, 1, 0, 3'd3, 16'd0, 0, 3'd5, 16'd0, 2'b01));
        apply(mk(0, 1, 1, 0, 3'd3, 16'd0, 0, 3'd5, 16'd0, 2'b10));

        // Read-after-write to the same address.
        apply(mk(0, 0, 1, 0, 3'd0, 16'd0, 1, 3'd2, 16'hBEEF, 2'b10));
        apply(mk(0, 1, 0, 0, 3'd2, 16'd0, 0, 3'd0, 16'd0, 2'b01));

        // Mixed contention with prio = 1: read wins first, then the held write.
        apply(mk(0, 1, 1, 1, 3'd6, 16'hA0A0, 0, 3'd6, 16'd0, 2'b10));
        apply(mk(0, 1, 1, 1, 3'd6, 16'hA0A0, 0, 3'd6, 16'd0, 2'b01));
        apply(mk(0, 0, 1, 0, 3'd0, 16'd0, 0, 3'd6, 16'd0, 2'b10));
        apply(mk(0, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));
        apply(mk(0, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));

`ifdef SP_RAM_ARB_STATS_EN
        apply(mk(1, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));
        rst = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 16'h7777; req1 = 1'b0;
        repeat (70000) @(posedge wclk);
        #1;
        last_addr = 3'd0; last_din = 16'h7777; exp_mem[0] = 16'h7777;
        chk_cnt_nx = 1'b1; e_cnt0 = 16'hFFFF; e_cnt1 = 16'h0000;
        apply(mk(0, 0, 0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 2'b00));
        chk_cnt_nx = 1'b0;
`endif

        stim_done = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge wclk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: monitor did not finish");
            $fatal(1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
